// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit combinational ALU between NREQ requesters,
// with an owner lock for multi-cycle chains and a registered one-cycle response path.
module alu_arbiter #(
  parameter int unsigned    NREQ     = 3,
  parameter int unsigned    CW       = 4,
  parameter int unsigned    LOCK_MAX = 4,
  parameter logic [CW-1:0]  ALU_OR   = CW'(5)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_lock_i,
  input  logic [NREQ*CW-1:0] req_ctrl_i,
  input  logic [NREQ*8-1:0] req_a_i,
  input  logic [NREQ*8-1:0] req_b_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [CW-1:0]     alu_ctrl_o,
  output logic [7:0]        alu_a_o,
  output logic [7:0]        alu_b_o,
  input  logic [7:0]        alu_out_i,
  input  logic              alu_zero_i,
  output logic [NREQ-1:0]   resp_valid_o,
  output logic [7:0]        resp_data_o,
  output logic              resp_zero_o,
  output logic              lock_timeout_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            timeout_q, timeout_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [7:0]      resp_data_q;
  logic            resp_zero_q;

  logic            gnt_vld;
  logic [PtrW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [PtrW-1:0] gnt_next;
  int unsigned     scan;

  // Winner selection: rotating scan from rr_ptr in ARB, owner only while locked.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    unique case (state_q)
      StArb: begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          scan = 32'(rr_ptr_q) + k;
          if (scan >= NREQ) scan = scan - NREQ;
          if (!gnt_vld && req_valid_i[PtrW'(scan)]) begin
            gnt_vld = 1'b1;
            gnt_idx = PtrW'(scan);
          end
        end
      end
      StLocked: begin
        gnt_vld = req_valid_i[owner_q];
        gnt_idx = owner_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt_oh   = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    gnt_next = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PtrW'(1);
  end

  always_comb begin
    req_ready_o = gnt_oh;
    if (gnt_vld) begin
      alu_ctrl_o = req_ctrl_i[32'(gnt_idx)*CW +: CW];
      alu_a_o    = req_a_i[32'(gnt_idx)*8 +: 8];
      alu_b_o    = req_b_i[32'(gnt_idx)*8 +: 8];
    end else begin
      alu_ctrl_o = ALU_OR;
      alu_a_o    = '0;
      alu_b_o    = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    timeout_d    = 1'b0;
    rr_ptr_d     = gnt_vld ? gnt_next : rr_ptr_q;
    resp_valid_d = gnt_oh;
    unique case (state_q)
      StArb: begin
        if (gnt_vld && req_lock_i[gnt_idx]) begin
          state_d    = StLocked;
          owner_d    = gnt_idx;
          lock_cnt_d = CntW'(1);
        end
      end
      StLocked: begin
        lock_cnt_d = lock_cnt_q + CntW'(1);
        if (!req_lock_i[owner_q]) begin
          state_d = StArb;
        end else if (32'(lock_cnt_d) == LOCK_MAX) begin
          // Forced release: the owner's final grant still happens this cycle.
          state_d   = StArb;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StArb;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      lock_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      timeout_q    <= timeout_d;
      resp_valid_q <= resp_valid_d;
      if (gnt_vld) begin
        resp_data_q <= alu_out_i;
        resp_zero_q <= alu_zero_i;
      end
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_data_o    = resp_data_q;
  assign resp_zero_o    = resp_zero_q;
  assign lock_timeout_o = timeout_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Table-driven bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned CW   = 4;
  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpAddc = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_lock, req_ready, resp_valid;
  logic [NREQ*CW-1:0] req_ctrl;
  logic [NREQ*8-1:0] req_a, req_b;
  logic [CW-1:0]     alu_ctrl;
  logic [7:0]        alu_a, alu_b, alu_out, resp_data;
  logic              alu_zero, resp_zero, lock_timeout;
  logic [8:0]        alu_res;
  logic              carry_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] lock;
    int         gnt;
    logic       to;
  } vec_t;

  typedef struct {
    logic [2:0] oh;
    logic [7:0] data;
    logic       zero;
    logic       to;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  logic [7:0] hold_data;
  logic       hold_zero;

  alu_arbiter #(.NREQ(NREQ), .CW(CW), .LOCK_MAX(4), .ALU_OR(OpOr)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_lock_i     (req_lock),
    .req_ctrl_i     (req_ctrl),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_ready_o    (req_ready),
    .alu_ctrl_o     (alu_ctrl),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_out_i      (alu_out),
    .alu_zero_i     (alu_zero),
    .resp_valid_o   (resp_valid),
    .resp_data_o    (resp_data),
    .resp_zero_o    (resp_zero),
    .lock_timeout_o (lock_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    case (c)
      OpAdd:   return {1'b0, a} + {1'b0, b};
      OpAddc:  return {1'b0, a} + {1'b0, b} + {8'd0, cin};
      OpAnd:   return {1'b0, a & b};
      OpOr:    return {1'b0, a | b};
      OpXor:   return {1'b0, a ^ b};
      default: return 9'd0;
    endcase
  endfunction

  // External ALU model with a carry flag that ADD/ADDC update.
  assign alu_res  = alu_fn(alu_ctrl, alu_a, alu_b, carry_q);
  assign alu_out  = alu_res[7:0];
  assign alu_zero = (alu_res[7:0] == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else if (alu_ctrl == OpAdd || alu_ctrl == OpAddc) carry_q <= alu_res[8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rand_ops();
    logic [3:0] pick[3];
    pick[0] = OpOr;
    pick[1] = OpAnd;
    pick[2] = OpXor;
    for (int i = 0; i < NREQ; i++) begin
      req_ctrl[i*CW +: CW] = pick[$urandom_range(0, 2)];
      req_a[i*8 +: 8]      = 8'($urandom);
      req_b[i*8 +: 8]      = 8'($urandom);
    end
  endtask

  task automatic add_vec(input logic [2:0] v, input logic [2:0] l, input int g, input logic t);
    vec_t e;
    e.valid = v;
    e.lock  = l;
    e.gnt   = g;
    e.to    = t;
    tbl.push_back(e);
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic run_cycle(input int g, input logic t, input bit use_c,
                           input logic [7:0] cdata, input logic czero);
    exp_t e;
    exp_t got;
    logic [8:0] r;
    #1;
    e.oh = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("req_ready", 32'(req_ready), 32'(e.oh));
    if (g < 0) begin
      chk("idle_alu", {20'd0, alu_ctrl, alu_a}, {20'd0, OpOr, 8'd0});
      chk("idle_alu_b", 32'(alu_b), 32'd0);
      e.data = hold_data;
      e.zero = hold_zero;
    end else if (use_c) begin
      e.data = cdata;
      e.zero = czero;
    end else begin
      r = alu_fn(req_ctrl[g*CW +: CW], req_a[g*8 +: 8], req_b[g*8 +: 8], 1'b0);
      e.data = r[7:0];
      e.zero = (r[7:0] == 8'd0);
    end
    e.to = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("resp_valid", 32'(resp_valid), 32'(got.oh));
    chk("resp_data", 32'(resp_data), 32'(got.data));
    chk("resp_zero", 32'(resp_zero), 32'(got.zero));
    chk("lock_timeout", 32'(lock_timeout), 32'(got.to));
    hold_data = got.data;
    hold_zero = got.zero;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_ctrl  = '0;
    req_a     = '0;
    req_b     = '0;
    hold_data = 8'd0;
    hold_zero = 1'b0;

    // Round robin, idle with rr_ptr held, lock timeout, locked owner idle.
    for (int i = 0; i < 6; i++) add_vec(3'b111, 3'b000, i % 3, 1'b0);
    for (int i = 0; i < 3; i++) add_vec(3'b000, 3'b000, -1, 1'b0);
    add_vec(3'b010, 3'b000, 1, 1'b0);
    for (int i = 0; i < 3; i++) add_vec(3'b000, 3'b000, -1, 1'b0);
    add_vec(3'b111, 3'b000, 2, 1'b0);
    for (int i = 0; i < 4; i++) add_vec(3'b011, 3'b001, 0, (i == 3));
    add_vec(3'b011, 3'b001, 1, 1'b0);
    add_vec(3'b101, 3'b100, 2, 1'b0);
    add_vec(3'b001, 3'b100, -1, 1'b0);
    add_vec(3'b001, 3'b100, -1, 1'b0);
    add_vec(3'b001, 3'b000, -1, 1'b0);
    add_vec(3'b001, 3'b000, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_zero", 32'(resp_zero), 32'd0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      req_valid = tbl[i].valid;
      req_lock  = tbl[i].lock;
      rand_ops();
      run_cycle(tbl[i].gnt, tbl[i].to, 1'b0, 8'd0, 1'b0);
    end

    // Carry chain under lock: rr_ptr is 1 here, others stay valid.
    req_valid = 3'b111;
    rand_ops();
    req_ctrl[CW +: CW] = OpAdd;
    req_a[8 +: 8]      = 8'hFF;
    req_b[8 +: 8]      = 8'h01;
    req_lock           = 3'b010;
    run_cycle(1, 1'b0, 1'b1, 8'h00, 1'b1);
    req_ctrl[CW +: CW] = OpAddc;
    req_a[8 +: 8]      = 8'h00;
    req_b[8 +: 8]      = 8'h00;
    req_lock           = 3'b000;
    run_cycle(1, 1'b0, 1'b1, 8'h01, 1'b0);
    rand_ops();
    run_cycle(2, 1'b0, 1'b0, 8'd0, 1'b0);

    // Reset mid-lock: req0 locks (rr_ptr -> 1), then reset lands inside the owner's next grant.
    req_valid = 3'b001;
    req_lock  = 3'b001;
    rand_ops();
    run_cycle(0, 1'b0, 1'b0, 8'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midlock_resp_valid", 32'(resp_valid), 32'd0);
    chk("midlock_lock_timeout", 32'(lock_timeout), 32'd0);
    chk("midlock_resp_data", 32'(resp_data), 32'd0);
    chk("midlock_sb_empty", 32'(sb.size()), 32'd0);
    hold_data = 8'd0;
    hold_zero = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 3'b111;
    req_lock  = 3'b000;
    rand_ops();
    run_cycle(0, 1'b0, 1'b0, 8'd0, 1'b0);
    rand_ops();
    run_cycle(1, 1'b0, 1'b0, 8'd0, 1'b0);
    req_valid = 3'b000;
    run_cycle(-1, 1'b0, 1'b0, 8'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
